// File: rtl/fp16_divider_seq_if.sv
// fp16_divider_seq_if: request/response bundle for the sequential FP16 divider
interface fp16_divider_seq_if;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        start;
    logic        clear;
    logic        busy;
    logic        valid;
    logic [15:0] result;
    logic        div_by_zero;
    modport master (output dividend, divisor, start, clear, input busy, valid, result, div_by_zero);
    modport slave (input dividend, divisor, start, clear, output busy, valid, result, div_by_zero);
endinterface

// File: rtl/fp16_divider_seq.sv
// fp16_divider_seq: sequential FP16 divider, 13-cycle restoring mantissa division
// followed by one normalise/round cycle; subnormals flush to zero.
module fp16_divider_seq #(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input logic clk,
    input logic reset,
    fp16_divider_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [11:0] rem;
    logic [12:0] q;
    logic [10:0] mb;
    logic sign;
    logic signed [6:0] qexp;
    logic [4:0] ea, eb;
    logic sgn, nan_case, dbz_case, zero_case, special, accept;
    logic [15:0] special_res;
    logic signed [6:0] exp_init;
    logic ge;
    logic [11:0] rem_diff;
    logic [12:0] qn;
    logic signed [6:0] en, ef;
    logic guard, sticky, rnd;
    logic [10:0] m11;
    logic [15:0] norm_res;
    assign ea = bus.dividend[14:10];
    assign eb = bus.divisor[14:10];
    assign sgn = bus.dividend[15] ^ bus.divisor[15];
    assign nan_case = (ea == 5'd31) || (eb == 5'd31);
    assign dbz_case = eb == 5'd0;
    assign zero_case = ea == 5'd0;
    assign special = nan_case || dbz_case || zero_case;
    assign special_res = nan_case ? 16'h7E00 : dbz_case ? {sgn, 15'h7C00} : 16'h0000;
    assign exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15;
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign ge = rem >= {1'b0, mb};
    assign rem_diff = ge ? rem - {1'b0, mb} : rem;
    // Quotient lies in (0.5, 2): at most one left shift normalises it.
    assign qn = q[12] ? q : {q[11:0], 1'b0};
    assign en = q[12] ? qexp : qexp - 7'sd1;
    assign guard = qn[1];
    assign sticky = (|rem) | qn[0];
    assign rnd = ROUND_NEAREST && guard && (sticky || qn[2]);
    assign m11 = {1'b0, qn[11:2]} + {10'd0, rnd};
    assign ef = m11[10] ? en + 7'sd1 : en;
    assign norm_res = ef >= 7'sd31 ? {sign, 15'h7C00} : ef <= 7'sd0 ? 16'h0000 : {sign, ef[4:0], m11[9:0]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            rem <= 12'd0;
            q <= 13'd0;
            mb <= 11'd0;
            sign <= 1'b0;
            qexp <= 7'sd0;
            bus.busy <= 1'b0;
            bus.valid <= 1'b0;
            bus.result <= 16'h0000;
            bus.div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt <= 4'd0;
            rem <= {2'b01, bus.dividend[9:0]};
            q <= 13'd0;
            mb <= {1'b1, bus.divisor[9:0]};
            sign <= sgn;
            qexp <= exp_init;
            state <= special ? DONE : DIV;
            bus.busy <= !special;
            bus.valid <= special;
            bus.result <= special ? special_res : 16'h0000;
            bus.div_by_zero <= special && !nan_case && dbz_case;
        end else if (bus.clear) begin
            state <= IDLE;
            cnt <= 4'd0;
            bus.busy <= 1'b0;
            bus.valid <= 1'b0;
            bus.result <= 16'h0000;
            bus.div_by_zero <= 1'b0;
        end else if (state == DIV) begin
            q <= {q[11:0], ge};
            rem <= rem_diff << 1;
            cnt <= cnt == 4'd12 ? 4'd0 : cnt + 4'd1;
            state <= cnt == 4'd12 ? NORM : DIV;
        end else if (state == NORM) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.valid <= 1'b1;
            bus.result <= norm_res;
        end
    end
endmodule

// File: tb/tb_fp16_divider_seq.sv
// tb_fp16_divider_seq: directed checks of the FP16 divider with both rounding modes
module tb_fp16_divider_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    fp16_divider_seq_if b1();
    fp16_divider_seq_if b0();
    fp16_divider_seq #(.ROUND_NEAREST(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    fp16_divider_seq #(.ROUND_NEAREST(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

    task automatic set_in(input logic [15:0] a, input logic [15:0] b, input logic st, input logic cl);
        b1.dividend = a; b1.divisor = b; b1.start = st; b1.clear = cl;
        b0.dividend = a; b0.divisor = b; b0.start = st; b0.clear = cl;
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1 set_in(a, b, 1'b1, 1'b0);
        @(posedge clk); #1 set_in(a, b, 1'b0, 1'b0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 set_in(16'h0, 16'h0, 1'b0, 1'b1);
        @(posedge clk); #1 set_in(16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({b1.busy, b1.valid, b1.div_by_zero, b1.result} !== 19'd0) begin
            errors++; $display("FAIL reset_state got %h required 0", {b1.busy, b1.valid, b1.div_by_zero, b1.result});
        end
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({b0.busy, b0.valid, b0.result} !== 18'd0) begin
            errors++; $display("FAIL reset_release got %h required 0", {b0.busy, b0.valid, b0.result});
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va [9] = '{16'h4000, 16'h3C00, 16'h3C00, 16'h3D00, 16'hC000, 16'h0000, 16'h7C00, 16'h7BFF, 16'h0400};
        logic [15:0] vb [9] = '{16'h3C00, 16'h4200, 16'h3E00, 16'h3E00, 16'h0000, 16'h4000, 16'h3C00, 16'h0400, 16'h7BFF};
        logic [15:0] rn [9] = '{16'h4000, 16'h3555, 16'h3955, 16'h3AAB, 16'hFC00, 16'h0000, 16'h7E00, 16'h7C00, 16'h0000};
        logic [15:0] tr [9] = '{16'h4000, 16'h3555, 16'h3955, 16'h3AAA, 16'hFC00, 16'h0000, 16'h7E00, 16'h7C00, 16'h0000};
        int lat [9] = '{15, 15, 15, 15, 1, 1, 1, 15, 15};
        logic dz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            launch(va[i], vb[i]);
            for (int k = 1; k <= lat[i]; k++) begin
                @(negedge clk);
                if (k == lat[i] - 1) begin
                    checks++;
                    if (b1.valid !== 1'b0) begin
                        errors++; $display("FAIL early_valid[%0d] got %b required 0", i, b1.valid);
                    end
                end
            end
            checks++;
            if (b1.valid !== 1'b1) begin
                errors++; $display("FAIL valid[%0d] got %b required 1", i, b1.valid);
            end
            checks++;
            if (b1.result !== rn[i]) begin
                errors++; $display("FAIL result_rne[%0d] got %h required %h", i, b1.result, rn[i]);
            end
            checks++;
            if (b0.result !== tr[i]) begin
                errors++; $display("FAIL result_trunc[%0d] got %h required %h", i, b0.result, tr[i]);
            end
            checks++;
            if (b1.div_by_zero !== dz[i]) begin
                errors++; $display("FAIL dbz[%0d] got %b required %b", i, b1.div_by_zero, dz[i]);
            end
            @(negedge clk);
            checks++;
            if ({b1.valid, b1.result} !== {1'b1, rn[i]}) begin
                errors++; $display("FAIL hold[%0d] got %h required %h", i, {b1.valid, b1.result}, {1'b1, rn[i]});
            end
            pulse_clear();
        end
    endtask

    task automatic test_busy_timing();
        launch(16'h4000, 16'h3C00);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checks++;
            if ({b1.busy, b1.valid} !== {k <= 14, k == 15}) begin
                errors++; $display("FAIL busy_valid_c%0d got %b required %b", k, {b1.busy, b1.valid}, {k <= 14, k == 15});
            end
        end
        checks++;
        if (b1.result !== 16'h4000) begin
            errors++; $display("FAIL timing_result got %h required 4000", b1.result);
        end
    endtask

    task automatic test_start_in_done();
        launch(16'h3C00, 16'h3E00);
        @(negedge clk);
        checks++;
        if ({b1.busy, b1.valid} !== 2'b10) begin
            errors++; $display("FAIL done_restart got %b required 10", {b1.busy, b1.valid});
        end
        for (int k = 2; k <= 15; k++) @(negedge clk);
        checks++;
        if ({b1.valid, b1.result} !== {1'b1, 16'h3955}) begin
            errors++; $display("FAIL done_restart_result got %h required 13955", {b1.valid, b1.result});
        end
    endtask

    task automatic test_start_in_div();
        pulse_clear();
        launch(16'h4000, 16'h3C00);
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1 set_in(16'h3C00, 16'h4200, 1'b1, 1'b0);
        @(posedge clk); #1 set_in(16'h0, 16'h0, 1'b0, 1'b0);
        for (int k = 4; k <= 15; k++) begin
            @(negedge clk);
            if (k == 14) begin
                checks++;
                if (b1.valid !== 1'b0) begin
                    errors++; $display("FAIL div_start_early got %b required 0", b1.valid);
                end
            end
        end
        checks++;
        if ({b1.valid, b1.result} !== {1'b1, 16'h4000}) begin
            errors++; $display("FAIL div_start_ignored got %h required 14000", {b1.valid, b1.result});
        end
    endtask

    task automatic test_clear();
        pulse_clear();
        @(negedge clk);
        checks++;
        if ({b1.busy, b1.valid, b1.div_by_zero, b1.result} !== 19'd0) begin
            errors++; $display("FAIL clear_done got %h required 0", {b1.busy, b1.valid, b1.div_by_zero, b1.result});
        end
        launch(16'h4000, 16'h3C00);
        for (int k = 1; k <= 15; k++) @(negedge clk);
        @(posedge clk); #1 set_in(16'h3C00, 16'h4200, 1'b1, 1'b1);
        @(posedge clk); #1 set_in(16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({b1.busy, b1.valid} !== 2'b10) begin
            errors++; $display("FAIL start_over_clear got %b required 10", {b1.busy, b1.valid});
        end
        pulse_clear();
    endtask

    task automatic test_clear_abort();
        bit seen = 1'b0;
        launch(16'h4000, 16'h3C00);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        @(posedge clk); #1 set_in(16'h0, 16'h0, 1'b1, 1'b1);
        @(posedge clk); #1 set_in(16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({b1.busy, b1.valid} !== 2'b00) begin
            errors++; $display("FAIL clear_abort got %b required 00", {b1.busy, b1.valid});
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen |= b1.valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_valid got %b required 0", seen);
        end
    endtask

    task automatic test_reset_mid_div();
        bit seen = 1'b0;
        launch(16'h3C00, 16'h4200);
        for (int k = 1; k <= 3; k++) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({b1.busy, b1.valid, b1.div_by_zero, b1.result} !== 19'd0) begin
            errors++; $display("FAIL reset_mid_div got %h required 0", {b1.busy, b1.valid, b1.div_by_zero, b1.result});
        end
        @(negedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen |= b1.valid | b1.busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_no_valid got %b required 0", seen);
        end
    endtask

    initial begin
        set_in(16'h0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_vectors();
        test_busy_timing();
        test_start_in_done();
        test_start_in_div();
        test_clear();
        test_clear_abort();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
